// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and in_valid; the slave (adder) returns registered results.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             p;
  logic             g;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  s, cout, ovf, p, g, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output s, cout, ovf, p, g, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder built from per-bit full-adder cells, with
// signed overflow, group propagate/generate, and a one-cycle valid qualifier.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  full_adder_if.slave   fa_if
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             p;
    logic             g;
  } result_t;

  logic [WIDTH:0]   carry_c;
  logic [WIDTH:0]   gen_carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             prop_c;
  result_t          res_c;

  result_t res_q;
  result_t res_d;
  logic    out_valid_q;
  logic    out_valid_d;

  // Ripple chain; a second chain with cin forced low yields the group generate.
  always_comb begin
    carry_c        = '0;
    gen_carry_c    = '0;
    sum_c          = '0;
    carry_c[0]     = fa_if.cin;
    gen_carry_c[0] = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]         = fa_if.a[i] ^ fa_if.b[i] ^ carry_c[i];
      carry_c[i+1]     = (fa_if.a[i] & fa_if.b[i]) |
                         (fa_if.a[i] & carry_c[i]) |
                         (fa_if.b[i] & carry_c[i]);
      gen_carry_c[i+1] = (fa_if.a[i] & fa_if.b[i]) |
                         (fa_if.a[i] & gen_carry_c[i]) |
                         (fa_if.b[i] & gen_carry_c[i]);
    end
    prop_c = &(fa_if.a ^ fa_if.b);
  end

  always_comb begin
    res_c      = '0;
    res_c.s    = sum_c;
    res_c.cout = carry_c[WIDTH];
    res_c.ovf  = carry_c[WIDTH] ^ carry_c[WIDTH-1];
    res_c.p    = prop_c;
    res_c.g    = gen_carry_c[WIDTH];
  end

  // Results hold while in_valid is low so idle operands never disturb them.
  always_comb begin
    res_d       = res_q;
    out_valid_d = 1'b0;
    if (fa_if.in_valid) begin
      res_d       = res_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fa_if.s         = res_q.s;
  assign fa_if.cout      = res_q.cout;
  assign fa_if.ovf       = res_q.ovf;
  assign fa_if.p         = res_q.p;
  assign fa_if.g         = res_q.g;
  assign fa_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .fa_if(if1.slave));
  full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .fa_if(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed results packed as {s, cout, ovf, p, g, out_valid}.
  function automatic logic [5:0] obs1();
    return {if1.s, if1.cout, if1.ovf, if1.p, if1.g, if1.out_valid};
  endfunction

  function automatic logic [12:0] obs8();
    return {if8.s, if8.cout, if8.ovf, if8.p, if8.g, if8.out_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1;
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b1; if8.in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (obs1() !== 6'b0) begin
        bad++;
        $display("FAIL reset_w1 cyc%0d: got %b expected %b", c, obs1(), 6'b0);
      end
      total++;
      if (obs8() !== 13'b0) begin
        bad++;
        $display("FAIL reset_w8 cyc%0d: got %b expected %b", c, obs8(), 13'b0);
      end
    end
    rst_n = 1'b1;
    step();
    // 1+1+1 -> s=1 cout=1 ovf=0 p=0 g=1 valid
    total++;
    if (obs1() !== 6'b1_1_0_0_1_1) begin
      bad++;
      $display("FAIL reset_release_w1: got %b expected %b", obs1(), 6'b110011);
    end
    // 01+01+1 -> 03, no carry, no ovf, p=0 g=0
    total++;
    if (obs8() !== {8'h03, 5'b0_0_0_0_1}) begin
      bad++;
      $display("FAIL reset_release_w8: got %b expected %b", obs8(), {8'h03, 5'b00001});
    end
  endtask

  task automatic test_truth_table();
    // {a,b,cin} -> {s,cout,ovf,p,g}
    logic [7:0] tbl [8];
    tbl[0] = {3'b000, 5'b0_0_0_0_0};
    tbl[1] = {3'b001, 5'b1_0_1_0_0};
    tbl[2] = {3'b010, 5'b1_0_0_1_0};
    tbl[3] = {3'b011, 5'b0_1_0_1_0};
    tbl[4] = {3'b100, 5'b1_0_0_1_0};
    tbl[5] = {3'b101, 5'b0_1_0_1_0};
    tbl[6] = {3'b110, 5'b0_1_1_0_1};
    tbl[7] = {3'b111, 5'b1_1_0_0_1};
    if1.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] row;
      row = tbl[i];
      if1.a = row[7]; if1.b = row[6]; if1.cin = row[5];
      step();
      total++;
      if (obs1() !== {row[4:0], 1'b1}) begin
        bad++;
        $display("FAIL truth_w1 abc=%b: got %b expected %b", row[7:5], obs1(), {row[4:0], 1'b1});
      end
    end
  endtask

  task automatic test_hold();
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b1; if8.in_valid = 1'b1;
    step();
    total++;
    if (obs8() !== {8'h47, 5'b0_0_0_0_1}) begin
      bad++;
      $display("FAIL hold_load: got %b expected %b", obs8(), {8'h47, 5'b00001});
    end
    if8.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        if8.a = 'x; if8.b = 'x; if8.cin = 1'bx;
      end else begin
        if8.a = 8'hFF; if8.b = 8'h0F; if8.cin = 1'b0;
      end
      step();
      total++;
      if (obs8() !== {8'h47, 5'b0_0_0_0_0}) begin
        bad++;
        $display("FAIL hold cyc%0d: got %b expected %b", c, obs8(), {8'h47, 5'b00000});
      end
    end
  endtask

  task automatic test_boundaries();
    // {a, b, cin, s, cout, ovf, p, g}
    logic [28:0] tbl [4];
    tbl[0] = {8'hFF, 8'h00, 1'b1, 8'h00, 4'b1_0_1_0};
    tbl[1] = {8'h7F, 8'h01, 1'b0, 8'h80, 4'b0_1_0_0};
    tbl[2] = {8'h80, 8'h80, 1'b0, 8'h00, 4'b1_1_0_1};
    tbl[3] = {8'hFF, 8'hFF, 1'b1, 8'hFF, 4'b1_0_0_1};
    if8.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [28:0] row;
      row = tbl[i];
      if8.a = row[28:21]; if8.b = row[20:13]; if8.cin = row[12];
      step();
      total++;
      if (obs8() !== {row[11:0], 1'b1}) begin
        bad++;
        $display("FAIL boundary_w8 #%0d: got %b expected %b", i, obs8(), {row[11:0], 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, s_exp;
    logic       cin, cout_exp, ovf_exp, p_exp, g_exp;
    logic [8:0] full, gen;
    if8.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      if8.a = a; if8.b = b; if8.cin = cin;
      full     = 9'(a) + 9'(b) + 9'(cin);
      gen      = 9'(a) + 9'(b);
      s_exp    = full[7:0];
      cout_exp = full[8];
      ovf_exp  = (a[7] == b[7]) && (s_exp[7] != a[7]);
      p_exp    = ((a ^ b) == 8'hFF);
      g_exp    = gen[8];
      step();
      total++;
      if (obs8() !== {s_exp, cout_exp, ovf_exp, p_exp, g_exp, 1'b1}) begin
        bad++;
        $display("FAIL stream #%0d a=%h b=%h cin=%b: got %b expected %b", i, a, b, cin,
                 obs8(), {s_exp, cout_exp, ovf_exp, p_exp, g_exp, 1'b1});
      end
      total++;
      if (if8.cout !== (if8.g | (if8.p & cin))) begin
        bad++;
        $display("FAIL pg_identity #%0d: got cout=%b expected %b", i, if8.cout,
                 if8.g | (if8.p & cin));
      end
    end
  endtask

  task automatic test_reset_midstream();
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.in_valid = 1'b1;
    step();
    total++;
    if (obs8() !== {8'h30, 5'b0_0_0_0_1}) begin
      bad++;
      $display("FAIL midreset_op1: got %b expected %b", obs8(), {8'h30, 5'b00001});
    end
    if8.a = 8'h55; if8.b = 8'hAA; if8.cin = 1'b1;
    rst_n = 1'b0;
    step();
    total++;
    if (obs8() !== 13'b0) begin
      bad++;
      $display("FAIL midreset_clear: got %b expected %b", obs8(), 13'b0);
    end
    rst_n = 1'b1;
    if8.in_valid = 1'b0;
    step();
    total++;
    if (obs8() !== 13'b0) begin
      bad++;
      $display("FAIL midreset_lost: got %b expected %b", obs8(), 13'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
